// File: rtl/subtract_arbiter.sv
// subtract_arbiter: two-requester round-robin front end for a single
// subtractor. It captures the winning operands, computes entry_1 - entry_2
// (wrapping modulo 2^WIDTH), and holds the difference for the LCD driver
// until the display acknowledges it.
// Optional feature: define SUB_BORROW_FLAG_EN to add the 'borrow' output
// (unsigned entry_1 < entry_2, registered with the result).
module subtract_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req0_entry_1,
  input  logic [WIDTH-1:0] req0_entry_2,
  input  logic [WIDTH-1:0] req1_entry_1,
  input  logic [WIDTH-1:0] req1_entry_2,
  output logic             req0_ack,
  output logic             req1_ack,
  output logic [WIDTH-1:0] result,
  output logic             result_id,
  output logic             show_result,
  input  logic             lcd_ack,
`ifdef SUB_BORROW_FLAG_EN
  output logic             borrow,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EXEC = 2'd2,
    S_SHOW = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_op1;
  logic [WIDTH-1:0] r_op2;
  logic [WIDTH-1:0] r_result;
  logic             r_id;
  logic             r_last;    // requester granted most recently
  logic             r_ack0;
  logic             r_ack1;
  logic             r_show;
`ifdef SUB_BORROW_FLAG_EN
  logic             r_borrow;
`endif

  logic             w_any;
  logic             w_win;
  logic [WIDTH-1:0] w_win_e1;
  logic [WIDTH-1:0] w_win_e2;

  // Round-robin pick: on contention the requester not granted last wins,
  // otherwise whichever requester is valid.
  always_comb begin
    w_any    = req0_valid | req1_valid;
    w_win    = (req0_valid & req1_valid) ? ~r_last : req1_valid;
    w_win_e1 = w_win ? req1_entry_1 : req0_entry_1;
    w_win_e2 = w_win ? req1_entry_2 : req0_entry_2;
  end

  // Control FSM with registered outputs; requests are only looked at in IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_op1    <= '0;
      r_op2    <= '0;
      r_result <= '0;
      r_id     <= 1'b0;
      r_last   <= 1'b1;  // so requester 0 wins the first contention
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_show   <= 1'b0;
`ifdef SUB_BORROW_FLAG_EN
      r_borrow <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_op1   <= w_win_e1;
            r_op2   <= w_win_e2;
            r_id    <= w_win;
            r_last  <= w_win;
            r_ack0  <= ~w_win;
            r_ack1  <= w_win;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_result <= r_op1 - r_op2;
`ifdef SUB_BORROW_FLAG_EN
          r_borrow <= (r_op1 < r_op2);
`endif
          r_show   <= 1'b1;
          r_state  <= S_SHOW;
        end
        S_SHOW: begin
          if (lcd_ack) begin
            r_show  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req0_ack    = r_ack0;
  assign req1_ack    = r_ack1;
  assign result      = r_result;
  assign result_id   = r_id;
  assign show_result = r_show;
  assign busy        = (r_state != S_IDLE);
`ifdef SUB_BORROW_FLAG_EN
  assign borrow      = r_borrow;
`endif

endmodule

// File: tb/tb_subtract_arbiter.sv
// Bench for subtract_arbiter: driver issues requests and pushes the expected
// difference into a per-requester queue; a negedge monitor runs a
// transaction-level model of the arbiter and scores every cycle.
module tb_subtract_arbiter;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0, lcd_ack = 1'b0;
  logic [W-1:0] req0_entry_1 = '0, req0_entry_2 = '0;
  logic [W-1:0] req1_entry_1 = '0, req1_entry_2 = '0;
  logic         req0_ack, req1_ack, result_id, show_result, busy;
  logic [W-1:0] result;
`ifdef SUB_BORROW_FLAG_EN
  logic         borrow;
`endif

  subtract_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_entry_1(req0_entry_1), .req0_entry_2(req0_entry_2),
    .req1_entry_1(req1_entry_1), .req1_entry_2(req1_entry_2),
    .req0_ack(req0_ack), .req1_ack(req1_ack),
    .result(result), .result_id(result_id), .show_result(show_result),
    .lcd_ack(lcd_ack),
`ifdef SUB_BORROW_FLAG_EN
    .borrow(borrow),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         brw;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   grant_log[$];
  int   n_checks = 0;
  int   n_err = 0;
  int   lcd_mode = 0;  // 0 random, 1 tied high, 2 held low
  bit   saw0, saw1;

  task automatic check(string nm, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  // ---------------- monitor / reference model ----------------
  bit   m_free = 1'b1, m_showing = 1'b0, m_last = 1'b1, m_id = 1'b0, m_win;
  int   m_cnt = 0;
  exp_t m_exp;
  logic p_v0 = 1'b0, p_v1 = 1'b0, p_lcd = 1'b0, p_rst = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n || !p_rst) begin
        check("rst_result", result, 0);
        check("rst_id", result_id, 0);
        check("rst_show", show_result, 0);
        check("rst_ack0", req0_ack, 0);
        check("rst_ack1", req1_ack, 0);
        check("rst_busy", busy, 0);
`ifdef SUB_BORROW_FLAG_EN
        check("rst_borrow", borrow, 0);
`endif
        m_free = 1'b1; m_showing = 1'b0; m_cnt = 0; m_last = 1'b1;
      end else if (m_free) begin
        if (p_v0 || p_v1) begin
          m_win = (p_v0 && p_v1) ? !m_last : p_v1;
          check("grant_ack0", req0_ack, !m_win);
          check("grant_ack1", req1_ack, m_win);
          check("grant_busy", busy, 1);
          m_last = m_win;
          m_id   = m_win;
          grant_log.push_back(int'(m_win));
          if (m_win) begin
            check("grant_q1", q1.size() > 0, 1);
            if (q1.size() > 0) m_exp = q1.pop_front();
          end else begin
            check("grant_q0", q0.size() > 0, 1);
            if (q0.size() > 0) m_exp = q0.pop_front();
          end
          m_free = 1'b0; m_cnt = 2;
        end else begin
          check("idle_ack0", req0_ack, 0);
          check("idle_ack1", req1_ack, 0);
          check("idle_busy", busy, 0);
          check("idle_show", show_result, 0);
        end
      end else if (!m_showing) begin
        check("run_ack0", req0_ack, 0);
        check("run_ack1", req1_ack, 0);
        check("run_busy", busy, 1);
        m_cnt--;
        if (m_cnt == 0) begin
          check("show_rise", show_result, 1);
          check("show_result", result, m_exp.diff);
          check("show_id", result_id, m_id);
`ifdef SUB_BORROW_FLAG_EN
          check("show_borrow", borrow, m_exp.brw);
`endif
          m_showing = 1'b1;
        end else begin
          check("exec_show", show_result, 0);
        end
      end else begin
        check("show_ack0", req0_ack, 0);
        check("show_ack1", req1_ack, 0);
        if (p_lcd) begin
          check("show_drop", show_result, 0);
          check("done_busy", busy, 0);
          m_free = 1'b1; m_showing = 1'b0;
        end else begin
          check("show_hold", show_result, 1);
          check("hold_result", result, m_exp.diff);
          check("hold_id", result_id, m_id);
          check("hold_busy", busy, 1);
`ifdef SUB_BORROW_FLAG_EN
          check("hold_borrow", borrow, m_exp.brw);
`endif
        end
      end
      p_v0 = req0_valid; p_v1 = req1_valid; p_lcd = lcd_ack; p_rst = reset_n;
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk); #2;
    saw0 = req0_ack;
    saw1 = req1_ack;
    if (req0_ack) req0_valid = 1'b0;
    if (req1_ack) req1_valid = 1'b0;
    case (lcd_mode)
      0:       lcd_ack = ($urandom_range(0, 2) == 0);
      1:       lcd_ack = 1'b1;
      default: lcd_ack = 1'b0;
    endcase
  endtask

  task automatic issue(int id, logic [W-1:0] a, logic [W-1:0] b);
    exp_t e;
    e.diff = W'((32'(a) + (32'd1 << W) - 32'(b)) % (32'd1 << W));
    e.brw  = (32'(a) < 32'(b));
    if (id == 0) begin
      req0_entry_1 = a; req0_entry_2 = b; req0_valid = 1'b1; q0.push_back(e);
    end else begin
      req1_entry_1 = a; req1_entry_2 = b; req1_valid = 1'b1; q1.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy || req0_valid || req1_valid) && k < 300) begin
      tick();
      k++;
    end
    check("idle_timeout", k < 300, 1);
  endtask

  int exp_seq[4] = '{0, 1, 0, 1};

  initial begin
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // single request and wrap-around
    issue(0, 16'h0009, 16'h0004);
    wait_idle();
    issue(1, 16'h0003, 16'h0005);
    wait_idle();

    // contention straight after reset: grants must alternate 0,1,0,1
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    grant_log.delete();
    issue(0, W'($urandom), W'($urandom));
    issue(1, W'($urandom), W'($urandom));
    for (int k = 0; k < 300 && grant_log.size() < 4; k++) begin
      tick();
      if (!req0_valid && grant_log.size() < 3) issue(0, W'($urandom), W'($urandom));
      if (!req1_valid && grant_log.size() < 3) issue(1, W'($urandom), W'($urandom));
    end
    check("grant_count", grant_log.size() >= 4, 1);
    if (grant_log.size() >= 4)
      for (int i = 0; i < 4; i++) check("rr_order", grant_log[i], exp_seq[i]);
    wait_idle();

    // display stall: lcd_ack low for 20 cycles in SHOW with both requesters waiting
    lcd_mode = 2;
    issue(0, W'($urandom), W'($urandom));
    issue(1, W'($urandom), W'($urandom));
    for (int k = 0; k < 50 && !show_result; k++) tick();
    check("stall_reach_show", show_result, 1);
    repeat (20) tick();
    lcd_mode = 0;
    wait_idle();

    // reset during EXEC: aborts with no show, outputs clear immediately
    issue(1, W'($urandom), W'($urandom));
    saw1 = 1'b0;
    for (int k = 0; k < 50 && !saw1; k++) tick();
    check("mid_ack_seen", saw1, 1);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("async_show", show_result, 0);
    check("async_busy", busy, 0);
    check("async_result", result, 0);
    check("async_id", result_id, 0);
    check("async_ack", {req0_ack, req1_ack}, 0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    issue(0, W'($urandom), W'($urandom));
    wait_idle();

    // lcd_ack tied high: one show cycle per operation
    lcd_mode = 1;
    repeat (4) begin
      issue(int'($urandom_range(0, 1)), W'($urandom), W'($urandom));
      wait_idle();
    end

    // random traffic
    lcd_mode = 0;
    repeat (400) begin
      tick();
      if (!req0_valid && $urandom_range(0, 3) == 0) issue(0, W'($urandom), W'($urandom));
      if (!req1_valid && $urandom_range(0, 3) == 0) issue(1, W'($urandom), W'($urandom));
    end
    wait_idle();
    repeat (3) tick();
    check("queues_drained", q0.size() + q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
